// File: rtl/dragon_pkg.sv
// Shared types and constants for the dragon_loader byte-stream program loader.
package dragon_pkg;

    localparam int         WORD_WIDTH     = 36;
    localparam int         BYTES_PER_WORD = 5;
    localparam logic [7:0] SYNC_BYTE      = 8'hA5;

    // Frame parser states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_WORD,
        ST_WRITE,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/dragon_if.sv
// Host byte stream plus the DragonRAM write port driven by the loader.
interface dragon_if
    import dragon_pkg::*;
#(
    parameter int AddressWidth = 10
);
    logic                    InValid;
    logic [7:0]              InData;
    logic                    InReady;
    logic                    WriteEnable;
    logic [AddressWidth-1:0] WriteAddress;
    logic [WORD_WIDTH-1:0]   WriteData;

    // Host / RAM side.
    modport master (
        output InValid, InData,
        input  InReady, WriteEnable, WriteAddress, WriteData
    );

    // Loader side.
    modport slave (
        input  InValid, InData,
        output InReady, WriteEnable, WriteAddress, WriteData
    );
endinterface

// File: rtl/dragon_word_assembler.sv
// Collects 5 big-endian payload bytes into one 36-bit RAM word.
// Only the low nibble of byte0 survives, so the shift register keeps 28 bits;
// the fifth byte is merged combinationally so the word is ready on its accept.
module dragon_word_assembler
    import dragon_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  ByteValid,
    input  logic [7:0]            ByteIn,
    output logic                  WordReady,
    output logic [WORD_WIDTH-1:0] WordData
);
    localparam logic [2:0] LAST_INDEX = 3'(BYTES_PER_WORD - 1);

    logic [27:0] shift_q;
    logic [2:0]  index_q;

    // Shift accepted bytes in and track the position within the word.
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_q <= '0;
            index_q <= '0;
        end else if (Clear) begin
            index_q <= '0;
        end else if (ByteValid) begin
            shift_q <= {shift_q[19:0], ByteIn};
            index_q <= (index_q == LAST_INDEX) ? 3'd0 : index_q + 3'd1;
        end
    end

    assign WordReady = ByteValid & (index_q == LAST_INDEX);
    assign WordData  = {shift_q, ByteIn};

endmodule

// File: rtl/dragon_loader.sv
// Frame parser that downloads 36-bit words into DragonRAM while halting the core.
module dragon_loader
    import dragon_pkg::*;
#(
    parameter int         AddressWidth = 10,
    parameter logic [7:0] SyncByte     = SYNC_BYTE
)
(
    input  logic     Clock,
    input  logic     Reset,
    dragon_if.slave  bus,
    output logic     CoreHalt,
    output logic     LoadDone,
    output logic     LoadError
);
    state_t state_q, state_d;

    logic                    in_ready, accept, is_sync, last_word;
    logic                    write_enable, core_halt;
    logic                    word_ready;
    logic [WORD_WIDTH-1:0]   word_data;
    logic [15:0]             addr_q, count_q, word_idx_q, count_next;
    logic [7:0]              sum_q, sum_next;
    logic [AddressWidth-1:0] base_addr, wr_addr_q;
    logic [WORD_WIDTH-1:0]   wr_data_q;
    logic                    load_done_q, load_error_q;

    // Ready is a pure function of state, held low while reset is applied.
    assign in_ready   = ~Reset & (state_q != ST_WRITE);
    assign accept     = bus.InValid & in_ready;
    assign is_sync    = (bus.InData == SyncByte);
    assign count_next = {count_q[7:0], bus.InData};
    assign sum_next   = sum_q + bus.InData;
    assign last_word  = (word_idx_q == count_q - 16'd1);
    assign base_addr  = AddressWidth'(addr_q);

    dragon_word_assembler u_assembler (
        .Clock     (Clock),
        .Reset     (Reset),
        .Clear     (accept & (state_q == ST_IDLE) & is_sync),
        .ByteValid (accept & (state_q == ST_WORD)),
        .ByteIn    (bus.InData),
        .WordReady (word_ready),
        .WordData  (word_data)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d      = state_q;
        write_enable = 1'b0;
        core_halt    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                core_halt = 1'b0;
                if (accept && is_sync) state_d = ST_ADDR_HI;
            end
            ST_ADDR_HI: if (accept) state_d = ST_ADDR_LO;
            ST_ADDR_LO: if (accept) state_d = ST_CNT_HI;
            ST_CNT_HI:  if (accept) state_d = ST_CNT_LO;
            ST_CNT_LO:  if (accept) state_d = (count_next == 16'd0) ? ST_CHECK : ST_WORD;
            ST_WORD:    if (word_ready) state_d = ST_WRITE;
            ST_WRITE: begin
                write_enable = 1'b1;
                state_d      = last_word ? ST_CHECK : ST_WORD;
            end
            ST_CHECK:   if (accept) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Header capture, checksum accumulation, word indexing and write-port registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addr_q       <= '0;
            count_q      <= '0;
            word_idx_q   <= '0;
            sum_q        <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    ST_IDLE: if (is_sync) begin
                        sum_q        <= '0;
                        load_error_q <= 1'b0;
                    end
                    ST_ADDR_HI, ST_ADDR_LO: begin
                        addr_q <= {addr_q[7:0], bus.InData};
                        sum_q  <= sum_next;
                    end
                    ST_CNT_HI, ST_CNT_LO: begin
                        count_q    <= count_next;
                        word_idx_q <= '0;
                        sum_q      <= sum_next;
                    end
                    ST_WORD: sum_q <= sum_next;
                    ST_CHECK: begin
                        if (sum_next == 8'h00) load_done_q  <= 1'b1;
                        else                   load_error_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Address and data are latched as the word completes and then held.
            if (word_ready) begin
                wr_addr_q <= base_addr + AddressWidth'(word_idx_q);
                wr_data_q <= word_data;
            end
            if (state_q == ST_WRITE && !last_word) word_idx_q <= word_idx_q + 16'd1;
        end
    end

    assign bus.InReady      = in_ready;
    assign bus.WriteEnable  = write_enable;
    assign bus.WriteAddress = wr_addr_q;
    assign bus.WriteData    = wr_data_q;
    assign CoreHalt         = core_halt;
    assign LoadDone         = load_done_q;
    assign LoadError        = load_error_q;

endmodule
